// File: rtl/register_file_pkg.sv
// Shared constants and helpers for the eight-entry register file.
package register_file_pkg;

    localparam int NREGS         = 8;
    localparam int PC_IDX        = 7;
    localparam int SP_IDX        = 6;
    localparam int DEFAULT_WIDTH = 16;

    // True when more than one bit of the select vector is set.
    function automatic logic multiHot(input logic [NREGS-1:0] vec);
        logic [NREGS-1:0] lowerCleared;
        lowerCleared = vec & (vec - NREGS'(1));
        return lowerCleared != '0;
    endfunction

endpackage

// File: rtl/register_file_reg_cell.sv
// One register of the file: async clear, load beats inc/dec, inc and dec together hold.
module reg_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             notReset,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (inc && !dec) begin
            q <= q + WIDTH'(1);
        end else if (dec && !inc) begin
            q <= q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/register_file.sv
// Eight-entry register file with wired-OR bus read, PC/SP step paths and sticky selector-fault flags.
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             notReset,
    input  logic [7:0]       regOes,
    input  logic [7:0]       regNotLoads,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             dataOutValid,
    input  logic             pcInc,
    input  logic             spInc,
    input  logic             spDec,
    input  logic             errClear,
    output logic             oeError,
    output logic             loadError,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] sp
);

    logic [NREGS-1:0][WIDTH-1:0] regs;

    for (genvar i = 0; i < NREGS; i++) begin : gCell
        logic cellInc;
        logic cellDec;

        if (i == PC_IDX) begin : gPc
            assign cellInc = pcInc;
            assign cellDec = 1'b0;
        end else if (i == SP_IDX) begin : gSp
            assign cellInc = spInc;
            assign cellDec = spDec;
        end else begin : gPlain
            assign cellInc = 1'b0;
            assign cellDec = 1'b0;
        end

        reg_cell #(.WIDTH(WIDTH)) uCell (
            .clock    (clock),
            .notReset (notReset),
            .load     (!regNotLoads[i]),
            .inc      (cellInc),
            .dec      (cellDec),
            .d        (dataIn),
            .q        (regs[i])
        );
    end

    // Wired-OR bus: contention shows up as the OR of the selected registers.
    always_comb begin
        dataOut = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (regOes[i]) begin
                dataOut = dataOut | regs[i];
            end
        end
    end

    assign dataOutValid = |regOes;
    assign pc           = regs[PC_IDX];
    assign sp           = regs[SP_IDX];

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            oeError   <= 1'b0;
            loadError <= 1'b0;
        end else begin
            if (multiHot(regOes)) begin
                oeError <= 1'b1;
            end else if (errClear) begin
                oeError <= 1'b0;
            end
            if (multiHot(~regNotLoads)) begin
                loadError <= 1'b1;
            end else if (errClear) begin
                loadError <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed stimulus queues expectations, a negedge monitor checks them.
module tb_register_file;

    typedef enum logic [2:0] {
        SEL_DOUT, SEL_VALID, SEL_PC, SEL_SP, SEL_OEERR, SEL_LDERR
    } sel_e;

    typedef struct {
        int          cyc;
        sel_e        sel;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        clock;
    logic        notReset;
    logic [7:0]  regOes;
    logic [7:0]  regNotLoads;
    logic [15:0] dataIn;
    logic [15:0] dataOut;
    logic        dataOutValid;
    logic        pcInc;
    logic        spInc;
    logic        spDec;
    logic        errClear;
    logic        oeError;
    logic        loadError;
    logic [15:0] pc;
    logic [15:0] sp;

    exp_t sbq[$];
    int   cyc    = 0;
    int   passed = 0;
    int   total  = 0;

    register_file #(.WIDTH(16)) dut (
        .clock        (clock),
        .notReset     (notReset),
        .regOes       (regOes),
        .regNotLoads  (regNotLoads),
        .dataIn       (dataIn),
        .dataOut      (dataOut),
        .dataOutValid (dataOutValid),
        .pcInc        (pcInc),
        .spInc        (spInc),
        .spDec        (spDec),
        .errClear     (errClear),
        .oeError      (oeError),
        .loadError    (loadError),
        .pc           (pc),
        .sp           (sp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic want(input sel_e sel, input logic [15:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sbq.push_back(e);
    endtask

    // Inputs change 1 time unit after the rising edge; idle values unless overridden.
    task automatic step();
        @(posedge clock);
        #1;
        regOes      = 8'h00;
        regNotLoads = 8'hFF;
        dataIn      = 16'h0000;
        pcInc       = 1'b0;
        spInc       = 1'b0;
        spDec       = 1'b0;
        errClear    = 1'b0;
    endtask

    always @(negedge clock) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            exp_t        e;
            logic [15:0] act;
            e = sbq.pop_front();
            case (e.sel)
                SEL_DOUT:  act = dataOut;
                SEL_VALID: act = {15'd0, dataOutValid};
                SEL_PC:    act = pc;
                SEL_SP:    act = sp;
                SEL_OEERR: act = {15'd0, oeError};
                default:   act = {15'd0, loadError};
            endcase
            total++;
            if (act === e.val) begin
                passed++;
            end else begin
                $display("FAIL %s (cycle %0d): got 0x%04h, expected 0x%04h", e.name, cyc, act, e.val);
            end
        end
    end

    initial begin
        notReset    = 1'b0;
        regOes      = 8'h00;
        regNotLoads = 8'hFF;
        dataIn      = 16'h0000;
        pcInc       = 1'b0;
        spInc       = 1'b0;
        spDec       = 1'b0;
        errClear    = 1'b0;

        // Reset state
        step();
        want(SEL_DOUT, 16'h0000, "rst_dout");
        want(SEL_VALID, 16'h0000, "rst_valid");
        want(SEL_PC, 16'h0000, "rst_pc");
        want(SEL_SP, 16'h0000, "rst_sp");
        want(SEL_OEERR, 16'h0000, "rst_oeerr");
        want(SEL_LDERR, 16'h0000, "rst_lderr");

        // Load r3 and read it back
        step(); notReset = 1'b1; regNotLoads = 8'hF7; dataIn = 16'h1234;
        step(); regOes = 8'h08;
        want(SEL_DOUT, 16'h1234, "r3_read");
        want(SEL_VALID, 16'h0001, "r3_valid");
        step();
        want(SEL_DOUT, 16'h0000, "idle_dout");
        want(SEL_VALID, 16'h0000, "idle_valid");

        // PC wrap and load-over-increment
        step(); regNotLoads = 8'h7F; dataIn = 16'hFFFE;
        step(); pcInc = 1'b1;
        want(SEL_PC, 16'hFFFE, "pc_load");
        step(); pcInc = 1'b1;
        want(SEL_PC, 16'hFFFF, "pc_inc1");
        step(); pcInc = 1'b1; regNotLoads = 8'h7F; dataIn = 16'h0100;
        want(SEL_PC, 16'h0000, "pc_wrap");
        step();
        want(SEL_PC, 16'h0100, "pc_load_beats_inc");

        // SP decrement wrap, inc+dec hold, increment wrap
        step(); regNotLoads = 8'hBF; dataIn = 16'h0000;
        step(); spDec = 1'b1;
        step(); spInc = 1'b1; spDec = 1'b1;
        want(SEL_SP, 16'hFFFF, "sp_dec_wrap");
        step(); spInc = 1'b1;
        want(SEL_SP, 16'hFFFF, "sp_incdec_hold");
        step(); regOes = 8'h80;
        want(SEL_SP, 16'h0000, "sp_inc_wrap");
        want(SEL_DOUT, 16'h0100, "r7_read");

        // Bus contention: OR read and sticky oeError
        step(); regNotLoads = 8'hFD; dataIn = 16'h00F0;
        step(); regNotLoads = 8'hFB; dataIn = 16'h0F00;
        step(); regOes = 8'h06;
        want(SEL_DOUT, 16'h0FF0, "or_read");
        want(SEL_OEERR, 16'h0000, "oeerr_not_yet");
        step();
        want(SEL_OEERR, 16'h0001, "oeerr_set");
        step();
        want(SEL_OEERR, 16'h0001, "oeerr_sticky");
        step(); errClear = 1'b1;
        want(SEL_OEERR, 16'h0001, "oeerr_before_clear");
        step(); errClear = 1'b1; regOes = 8'h06;
        want(SEL_OEERR, 16'h0000, "oeerr_cleared");
        step();
        want(SEL_OEERR, 16'h0001, "oeerr_set_wins");
        want(SEL_LDERR, 16'h0000, "lderr_still_clear");

        // Multi-load and same-cycle read/write
        step(); regNotLoads = 8'hF9; dataIn = 16'hABCD;
        step(); regOes = 8'h02;
        want(SEL_DOUT, 16'hABCD, "multi_load_r1");
        want(SEL_LDERR, 16'h0001, "lderr_set");
        step(); regOes = 8'h04; regNotLoads = 8'hFB; dataIn = 16'h5555;
        want(SEL_DOUT, 16'hABCD, "rw_old_value");
        step(); regOes = 8'h04;
        want(SEL_DOUT, 16'h5555, "rw_new_value");
        step(); regOes = 8'h02; errClear = 1'b1;
        want(SEL_DOUT, 16'hABCD, "r1_unchanged");
        want(SEL_LDERR, 16'h0001, "lderr_sticky");
        step();
        want(SEL_LDERR, 16'h0000, "lderr_cleared");
        want(SEL_OEERR, 16'h0000, "oeerr_cleared2");

        // Asynchronous reset with everything pending
        step(); regOes = 8'h03; regNotLoads = 8'hFC; dataIn = 16'hFFFF;
        step();
        want(SEL_OEERR, 16'h0001, "pre_rst_oeerr");
        want(SEL_LDERR, 16'h0001, "pre_rst_lderr");
        want(SEL_PC, 16'h0100, "pre_rst_pc");
        step(); regOes = 8'h80; regNotLoads = 8'h00; dataIn = 16'hFFFF;
        pcInc = 1'b1; spInc = 1'b1;
        #2 notReset = 1'b0;
        want(SEL_DOUT, 16'h0000, "async_rst_dout");
        want(SEL_PC, 16'h0000, "async_rst_pc");
        want(SEL_SP, 16'h0000, "async_rst_sp");
        want(SEL_OEERR, 16'h0000, "async_rst_oeerr");
        want(SEL_LDERR, 16'h0000, "async_rst_lderr");
        step(); notReset = 1'b1; regNotLoads = 8'hEF; dataIn = 16'h4242; regOes = 8'h01;
        want(SEL_DOUT, 16'h0000, "rst_held_r0");
        want(SEL_PC, 16'h0000, "rst_held_pc");
        step(); regOes = 8'h10;
        want(SEL_DOUT, 16'h4242, "post_rst_load");
        want(SEL_SP, 16'h0000, "post_rst_sp");
        step();

        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clock);
        if (sbq.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
